// File: rtl/addrc_line_server.sv
// Data-side responder for the addRC controller: operand table loaded by the host,
// result table filled by the controller, then streamed back to the host in line order.
module addrc_line_server #(
   parameter int DATA_W = 8,
   parameter int RES_W  = 9,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_a,
   input  logic [DATA_W-1:0] ld_b,
   input  logic              read_file,
   input  logic [IDX_W-1:0]  line_index,
   input  logic              write_reg,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              write_file,
   input  logic [RES_W-1:0]  res_in,
   input  logic              finish,
   output logic              out_valid,
   output logic [RES_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              run_done,
   output logic              proto_err
);

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_COLLECT = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  ld_ptr_q, ld_ptr_d;
   logic [IDX_W:0]    wr_cnt_q, wr_cnt_d;
   logic [DEPTH-1:0]  written_q, written_d;
   logic [IDX_W-1:0]  out_ptr_q, out_ptr_d;
   logic [RES_W-1:0]  out_data_q, out_data_d;
   logic              run_done_q, run_done_d;
   logic              proto_err_q, proto_err_d;

   logic [DATA_W-1:0] a_mem_q   [DEPTH];
   logic [DATA_W-1:0] b_mem_q   [DEPTH];
   logic [RES_W-1:0]  res_mem_q [DEPTH];

   logic              ld_fire;
   logic              res_we;
   logic [IDX_W-1:0]  out_ptr_nxt;

   assign ld_fire     = (state_q == ST_LOAD) && ld_valid;
   assign out_ptr_nxt = out_ptr_q + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      ld_ptr_d    = ld_ptr_q;
      wr_cnt_d    = wr_cnt_q;
      written_d   = written_q;
      out_ptr_d   = out_ptr_q;
      out_data_d  = out_data_q;
      run_done_d  = 1'b0;
      proto_err_d = proto_err_q;
      res_we      = 1'b0;

      if (write_reg && (state_q != ST_COLLECT)) begin
         proto_err_d = 1'b1;
      end

      case (state_q)
         ST_LOAD: begin
            if (read_file || write_file || finish) begin
               proto_err_d = 1'b1;
            end
            if (ld_valid) begin
               ld_ptr_d = ld_ptr_q + IDX_W'(1);
               if (ld_ptr_q == LAST_IDX) begin
                  state_d = ST_ARMED;
               end
            end
         end

         ST_ARMED: begin
            if (write_file || finish) begin
               proto_err_d = 1'b1;
            end
            if (read_file) begin
               state_d   = ST_COLLECT;
               wr_cnt_d  = '0;
               written_d = '0;
            end
         end

         ST_COLLECT: begin
            if (read_file) begin
               // A second start abandons the partial run; the write this cycle is dropped too.
               proto_err_d = 1'b1;
               wr_cnt_d    = '0;
               written_d   = '0;
            end else begin
               if (write_file) begin
                  res_we = 1'b1;
                  if (written_q[line_index]) begin
                     proto_err_d = 1'b1;
                  end else begin
                     written_d[line_index] = 1'b1;
                     wr_cnt_d              = wr_cnt_q + (IDX_W + 1)'(1);
                  end
               end
               if (finish) begin
                  if (wr_cnt_d != FULL_CNT) begin
                     proto_err_d = 1'b1;
                  end
                  state_d   = ST_DRAIN;
                  out_ptr_d = '0;
                  // Bypass so a same-cycle write to line 0 is what the host sees first.
                  if (write_file && (line_index == '0)) begin
                     out_data_d = res_in;
                  end else begin
                     out_data_d = res_mem_q[0];
                  end
               end
            end
         end

         ST_DRAIN: begin
            if (read_file || write_file || finish) begin
               proto_err_d = 1'b1;
            end
            if (out_ready) begin
               if (out_ptr_q == LAST_IDX) begin
                  state_d    = ST_LOAD;
                  out_ptr_d  = '0;
                  out_data_d = '0;
                  run_done_d = 1'b1;
               end else begin
                  out_ptr_d  = out_ptr_nxt;
                  out_data_d = res_mem_q[out_ptr_nxt];
               end
            end
         end

         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         ld_ptr_q    <= '0;
         wr_cnt_q    <= '0;
         written_q   <= '0;
         out_ptr_q   <= '0;
         out_data_q  <= '0;
         run_done_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_ptr_q    <= ld_ptr_d;
         wr_cnt_q    <= wr_cnt_d;
         written_q   <= written_d;
         out_ptr_q   <= out_ptr_d;
         out_data_q  <= out_data_d;
         run_done_q  <= run_done_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Table storage has no reset; the host always reloads before a run.
   always_ff @(posedge clk) begin
      if (ld_fire) begin
         a_mem_q[ld_ptr_q] <= ld_a;
         b_mem_q[ld_ptr_q] <= ld_b;
      end
      if (res_we) begin
         res_mem_q[line_index] <= res_in;
      end
   end

   assign ld_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_DRAIN);
   assign out_data  = out_data_q;
   assign run_done  = run_done_q;
   assign proto_err = proto_err_q;
   assign op_a      = a_mem_q[line_index];
   assign op_b      = b_mem_q[line_index];

endmodule
